countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per one-second decrement; legal range 2 to 2^26.
REQ-002 Port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 Port reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port load, input, 1, synchronous strobe: copy preset into count, enter IDLE.
REQ-005 Port preset_mm, input, 8, BCD minutes preset, tens digit in [7:4], units in [3:0].
REQ-006 Port preset_ss, input, 8, BCD seconds preset, same packing.
REQ-007 Port start_stop, input, 1, single-cycle synchronous pulse that toggles run/pause.
REQ-008 Port mm, output, 8, current BCD minutes.
REQ-009 Port ss, output, 8, current BCD seconds.
REQ-010 Port running, output, 1, high only in RUN.
REQ-011 Port done, output, 1, level, high only in DONE.
REQ-012 Port done_pulse, output, 1, one-cycle strobe on the cycle DONE is entered.

Function
REQ-013 FSM states IDLE, RUN, PAUSE, DONE; every output is registered.
REQ-014 Prescaler counts 0 to TICK_DIV-1 only in RUN; tick is asserted on the cycle it equals TICK_DIV-1, and it then wraps to 0.
REQ-015 Prescaler holds its value in PAUSE; it clears on load, on reset, and on entry to DONE.
REQ-016 On tick in RUN, count decrements by one second: ss units, then ss tens (wrap 0 to 5), then mm units, then mm tens (wrap 0 to 9), as BCD borrow chain.
REQ-017 When the decrement result is 00:00, the same edge writes 00:00, moves to DONE, drives done=1 and running=0, and pulses done_pulse for one cycle.
REQ-018 IDLE + start_stop with count not 00:00 -> RUN; IDLE + start_stop with count 00:00 -> stays IDLE, no done_pulse.
REQ-019 RUN + start_stop -> PAUSE, count frozen; a tick coinciding with start_stop is applied first, then the state pauses.
REQ-020 PAUSE + start_stop -> RUN, with the prescaler resumed from its held value.
REQ-021 DONE ignores start_stop; only load or reset leave DONE.
REQ-022 load has priority over start_stop and tick in the same cycle: count = clamped preset, prescaler = 0, state = IDLE, done = 0.
REQ-023 Clamp on load: a units digit >9 loads 9; an ss tens digit >5 loads 5; an mm tens digit >9 loads 9.
REQ-024 Maximum count is 99:59.
REQ-025 Decrement latency: mm/ss change on the same edge that tick is asserted; no extra pipeline stage.

Reset
REQ-026 reset_n low asynchronously forces state IDLE, prescaler 0, mm=8'h00, ss=8'h00, running=0, done=0, done_pulse=0.
REQ-027 Reset asserted mid-RUN takes effect immediately, with no partial decrement.
REQ-028 After reset_n rises, the first state change occurs no earlier than the next rising clk edge.

Verification (TICK_DIV=4)
REQ-029 load preset 00:03, start_stop -> running=1; ss steps 03,02,01,00 every 4 cycles; done=1 and a one-cycle done_pulse with ss=00.
REQ-030 load 10:00, start, one tick -> mm=09, ss=59; 01:00 after one tick -> 00:59.
REQ-031 load 00:05, start, pause after 6 cycles -> ss=04 held through 20 cycles; resume -> next decrement after the remaining 2 prescaler cycles.
REQ-032 load and start_stop pulsed in the same cycle with preset 00:02 -> IDLE, running=0, ss=02; start at 00:00 -> no state change, done=0.
REQ-033 load preset_mm=8'hAF, preset_ss=8'h7C -> mm=8'h99, ss=8'h59.
REQ-034 reset_n pulsed low mid-RUN between clk edges -> all outputs zero immediately; in DONE, load 00:01 -> done=0, IDLE.

Source files
------------

// File: rtl/countdown_timer.sv
// Countdown timer with a BCD MM:SS count, a clock-cycle prescaler that
// produces a one-second tick, and an IDLE/RUN/PAUSE/DONE control FSM.
//
// Handshake: there is no valid/ready pair here. load and start_stop are
// single-cycle strobes sampled on the rising clk edge. Every output changes
// only on that edge, except for the asynchronous reset.
module countdown_timer #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [7:0] preset_mm,
   input  logic [7:0] preset_ss,
   input  logic       start_stop,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       running,
   output logic       done,
   output logic       done_pulse,
   output logic [1:0] state_dbg
);

   localparam int unsigned   PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]    state;
   logic [PW-1:0] presc;
   logic          tick;
   logic [7:0]    dec_mm;
   logic [7:0]    dec_ss;
   logic          dec_zero;
   logic          cnt_zero;
   logic [7:0]    clamp_mm;
   logic [7:0]    clamp_ss;

   assign state_dbg = state;

   // One-second tick: last prescaler cycle while running.
   always_comb begin
      tick     = (state == ST_RUN) && (presc == PRESC_MAX);
      cnt_zero = (mm == 8'h00) && (ss == 8'h00);
   end

   // One-second BCD decrement with a borrow chain from ss units to mm tens.
   always_comb begin
      dec_mm = mm;
      dec_ss = ss;
      if (ss[3:0] != 4'd0) begin
         dec_ss[3:0] = ss[3:0] - 4'd1;
      end else begin
         dec_ss[3:0] = 4'd9;
         if (ss[7:4] != 4'd0) begin
            dec_ss[7:4] = ss[7:4] - 4'd1;
         end else begin
            dec_ss[7:4] = 4'd5;
            if (mm[3:0] != 4'd0) begin
               dec_mm[3:0] = mm[3:0] - 4'd1;
            end else begin
               dec_mm[3:0] = 4'd9;
               if (mm[7:4] != 4'd0) begin
                  dec_mm[7:4] = mm[7:4] - 4'd1;
               end else begin
                  dec_mm[7:4] = 4'd9;
               end
            end
         end
      end
      dec_zero = (dec_mm == 8'h00) && (dec_ss == 8'h00);
   end

   // Preset clamp: out-of-range BCD digits saturate to their largest legal value.
   always_comb begin
      clamp_mm[7:4] = (preset_mm[7:4] > 4'd9) ? 4'd9 : preset_mm[7:4];
      clamp_mm[3:0] = (preset_mm[3:0] > 4'd9) ? 4'd9 : preset_mm[3:0];
      clamp_ss[7:4] = (preset_ss[7:4] > 4'd5) ? 4'd5 : preset_ss[7:4];
      clamp_ss[3:0] = (preset_ss[3:0] > 4'd9) ? 4'd9 : preset_ss[3:0];
   end

   // Control FSM, prescaler and registered outputs. load outranks everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         presc      <= '0;
         mm         <= 8'h00;
         ss         <= 8'h00;
         running    <= 1'b0;
         done       <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         if (load) begin
            state   <= ST_IDLE;
            presc   <= '0;
            mm      <= clamp_mm;
            ss      <= clamp_ss;
            running <= 1'b0;
            done    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  // Starting from 00:00 would finish immediately; ignore it.
                  if (start_stop && !cnt_zero) begin
                     state   <= ST_RUN;
                     running <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (tick) begin
                     // The decrement lands on the tick edge itself.
                     presc <= '0;
                     mm    <= dec_mm;
                     ss    <= dec_ss;
                     if (dec_zero) begin
                        state      <= ST_DONE;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        done_pulse <= 1'b1;
                     end else if (start_stop) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                     end
                  end else begin
                     presc <= presc + 1'b1;
                     if (start_stop) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                     end
                  end
               end
               ST_PAUSE: begin
                  // Prescaler keeps its value so the second resumes where it left off.
                  if (start_stop) begin
                     state   <= ST_RUN;
                     running <= 1'b1;
                  end
               end
               ST_DONE: begin
                  // Only load or reset leave DONE.
               end
               default: begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
                  done    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with a four-cycle second. The driver pushes the
// expected output snapshot and the cycle it should appear on; the monitor
// pops one entry every time the DUT outputs change and compares.
module tb_countdown_timer;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   localparam int W = 53;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       load = 1'b0;
   logic [7:0] preset_mm = 8'h00;
   logic [7:0] preset_ss = 8'h00;
   logic       start_stop = 1'b0;
   logic [7:0] mm;
   logic [7:0] ss;
   logic       running;
   logic       done;
   logic       done_pulse;
   logic [1:0] state_dbg;

   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;

   // Entry layout: {cycle[31:0], state[1:0], mm[7:0], ss[7:0], running, done, done_pulse}
   logic [W-1:0] exp_q[$];
   string        name_q[$];

   countdown_timer #(.TICK_DIV(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .preset_mm  (preset_mm),
      .preset_ss  (preset_ss),
      .start_stop (start_stop),
      .mm         (mm),
      .ss         (ss),
      .running    (running),
      .done       (done),
      .done_pulse (done_pulse),
      .state_dbg  (state_dbg)
   );

   // Clock and cycle counter
   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Push an expected snapshot due d rising edges from now.
   function automatic void expect_snap(input int d, input logic [1:0] st,
                                       input logic [7:0] m, input logic [7:0] s,
                                       input logic r, input logic dn, input logic p,
                                       input string nm);
      logic [31:0] c;
      c = 32'(cyc) + 32'(d);
      exp_q.push_back({c, st, m, s, r, dn, p});
      name_q.push_back(nm);
   endfunction

   // Drive one-cycle strobes starting at a falling edge.
   task automatic pulse(input logic l, input logic s, input logic [7:0] pm, input logic [7:0] ps);
      load       = l;
      start_stop = s;
      preset_mm  = pm;
      preset_ss  = ps;
      @(negedge clk);
      load       = 1'b0;
      start_stop = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: sample after each falling clk edge and on reset assertion.
   initial begin : monitor
      logic [20:0]  prev;
      logic [20:0]  cur;
      logic [W-1:0] e;
      string        nm;
      prev = '1;
      forever begin
         @(negedge clk or negedge reset_n);
         #1;
         cur = {state_dbg, mm, ss, running, done, done_pulse};
         if (cur != prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change cyc=%0d got snap=%h", cyc, cur);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               if (e != {cyc, cur}) begin
                  failures++;
                  $display("FAIL %s got cyc=%0d st=%0d mm=%h ss=%h r=%b d=%b p=%b exp cyc=%0d st=%0d mm=%h ss=%h r=%b d=%b p=%b",
                           nm, cyc, cur[20:19], cur[18:11], cur[10:3], cur[2], cur[1], cur[0],
                           e[52:21], e[20:19], e[18:11], e[10:3], e[2], e[1], e[0]);
               end
            end
            prev = cur;
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Directed stimulus
   initial begin
      // Reset
      expect_snap(0, ST_IDLE, 8'h00, 8'h00, 0, 0, 0, "reset");
      #1 reset_n = 1'b0;
      wait_cycles(2);
      reset_n = 1'b1;
      wait_cycles(1);

      // 00:03 counts down to DONE
      expect_snap(1, ST_IDLE, 8'h00, 8'h03, 0, 0, 0, "load_0003");
      pulse(1, 0, 8'h00, 8'h03);
      expect_snap(1,  ST_RUN,  8'h00, 8'h03, 1, 0, 0, "start_0003");
      expect_snap(5,  ST_RUN,  8'h00, 8'h02, 1, 0, 0, "tick_02");
      expect_snap(9,  ST_RUN,  8'h00, 8'h01, 1, 0, 0, "tick_01");
      expect_snap(13, ST_DONE, 8'h00, 8'h00, 0, 1, 1, "done_enter");
      expect_snap(14, ST_DONE, 8'h00, 8'h00, 0, 1, 0, "done_pulse_drop");
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(15);

      // Minute borrow 10:00 -> 09:59, load in RUN, 01:00 -> 00:59
      expect_snap(1, ST_IDLE, 8'h10, 8'h00, 0, 0, 0, "load_1000");
      pulse(1, 0, 8'h10, 8'h00);
      expect_snap(1, ST_RUN, 8'h10, 8'h00, 1, 0, 0, "start_1000");
      expect_snap(5, ST_RUN, 8'h09, 8'h59, 1, 0, 0, "borrow_0959");
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(4);
      expect_snap(1, ST_IDLE, 8'h01, 8'h00, 0, 0, 0, "load_in_run_0100");
      pulse(1, 0, 8'h01, 8'h00);
      expect_snap(1, ST_RUN, 8'h01, 8'h00, 1, 0, 0, "start_0100");
      expect_snap(5, ST_RUN, 8'h00, 8'h59, 1, 0, 0, "borrow_0059");
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(4);
      // load and start together: load wins
      expect_snap(1, ST_IDLE, 8'h00, 8'h02, 0, 0, 0, "load_start_same_cycle");
      pulse(1, 1, 8'h00, 8'h02);
      // start at 00:00 is ignored
      expect_snap(1, ST_IDLE, 8'h00, 8'h00, 0, 0, 0, "load_0000");
      pulse(1, 0, 8'h00, 8'h00);
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(3);

      // Pause holds count and prescaler; resume finishes the partial second
      expect_snap(1, ST_IDLE, 8'h00, 8'h05, 0, 0, 0, "load_0005");
      pulse(1, 0, 8'h00, 8'h05);
      expect_snap(1, ST_RUN,   8'h00, 8'h05, 1, 0, 0, "start_0005");
      expect_snap(5, ST_RUN,   8'h00, 8'h04, 1, 0, 0, "tick_04");
      expect_snap(7, ST_PAUSE, 8'h00, 8'h04, 0, 0, 0, "pause");
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(5);
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(20);
      expect_snap(1,  ST_RUN,  8'h00, 8'h04, 1, 0, 0, "resume");
      expect_snap(3,  ST_RUN,  8'h00, 8'h03, 1, 0, 0, "resume_tick_03");
      expect_snap(7,  ST_RUN,  8'h00, 8'h02, 1, 0, 0, "resume_tick_02");
      expect_snap(11, ST_RUN,  8'h00, 8'h01, 1, 0, 0, "resume_tick_01");
      expect_snap(15, ST_DONE, 8'h00, 8'h00, 0, 1, 1, "resume_done");
      expect_snap(16, ST_DONE, 8'h00, 8'h00, 0, 1, 0, "resume_done_drop");
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(16);
      // DONE ignores start_stop; load leaves DONE
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(2);
      expect_snap(1, ST_IDLE, 8'h00, 8'h01, 0, 0, 0, "load_from_done");
      pulse(1, 0, 8'h00, 8'h01);
      wait_cycles(2);

      // Tick coinciding with start_stop: decrement then pause
      expect_snap(1, ST_IDLE, 8'h00, 8'h03, 0, 0, 0, "load_0003_b");
      pulse(1, 0, 8'h00, 8'h03);
      expect_snap(1, ST_RUN,   8'h00, 8'h03, 1, 0, 0, "start_0003_b");
      expect_snap(5, ST_PAUSE, 8'h00, 8'h02, 0, 0, 0, "tick_and_pause");
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(3);
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(3);
      expect_snap(1,  ST_RUN,  8'h00, 8'h02, 1, 0, 0, "resume_b");
      expect_snap(5,  ST_RUN,  8'h00, 8'h01, 1, 0, 0, "resume_b_tick_01");
      expect_snap(9,  ST_DONE, 8'h00, 8'h00, 0, 1, 1, "resume_b_done");
      expect_snap(10, ST_DONE, 8'h00, 8'h00, 0, 1, 0, "resume_b_done_drop");
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(12);

      // Clamp on load, then asynchronous reset mid-RUN
      expect_snap(1, ST_IDLE, 8'h99, 8'h59, 0, 0, 0, "load_clamp");
      pulse(1, 0, 8'hAF, 8'h7C);
      expect_snap(1, ST_RUN, 8'h99, 8'h59, 1, 0, 0, "start_9959");
      expect_snap(5, ST_RUN, 8'h99, 8'h58, 1, 0, 0, "tick_9958");
      pulse(0, 1, 8'h00, 8'h00);
      wait_cycles(5);
      expect_snap(0, ST_IDLE, 8'h00, 8'h00, 0, 0, 0, "async_reset_mid_run");
      #2 reset_n = 1'b0;
      #2 reset_n = 1'b1;
      wait_cycles(6);

      // Nothing left unmatched
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got %0d pending entries, exp 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
